// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the two-master on-chip memory arbiter.
package onchip_mem_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 25000;

  // DEPTH must stay below 2**ADDR_W for this compare value to be meaningful.
  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } mem_cmd_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic oob;
  } rd_tag_t;

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
    return addr >= DEPTH_LIMIT;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    // No grants while reset is held, so nothing reaches memory or the read pipe.
    if (!reset) begin
      case (req)
        2'b01: begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end
        2'b10: begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
        2'b11: begin
          gnt_valid = 1'b1;
          gnt_id    = rr_ptr_q;
        end
        default: begin
          gnt_valid = 1'b0;
          gnt_id    = 1'b0;
        end
      endcase
    end
    gnt      = gnt_valid ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    rr_ptr_d = gnt_valid ? ~gnt_id : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port on-chip memory between two pipelined Avalon-MM masters,
// with round-robin grant, out-of-range guarding and a 1-deep read return pipe.
module onchip_memory_arbiter
  import onchip_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_valid;
  logic              gnt_id;
  mem_cmd_t          cmd0;
  mem_cmd_t          cmd1;
  mem_cmd_t          cmd_sel;
  logic              cmd_oob;
  logic              fwd;
  rd_tag_t           tag_d;
  rd_tag_t           tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Write wins when a master raises read and write together.
  always_comb begin
    cmd0 = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, write: m0_write};
    cmd1 = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, write: m1_write};
    cmd_sel = gnt_id ? cmd1 : cmd0;
    cmd_oob = addr_oob(cmd_sel.addr);
    fwd     = gnt_valid & ~cmd_oob;
    tag_d   = '{valid: gnt_valid & ~cmd_sel.write, owner: gnt_id, oob: cmd_oob};
  end

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // Memory pins follow the granted command; otherwise they hold the last issued one.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (fwd) begin
      addr_q  <= cmd_sel.addr;
      be_q    <= cmd_sel.be;
      wdata_q <= cmd_sel.wdata;
    end
  end

  assign mem_address    = fwd ? cmd_sel.addr  : addr_q;
  assign mem_byteenable = fwd ? cmd_sel.be    : be_q;
  assign mem_writedata  = fwd ? cmd_sel.wdata : wdata_q;
  assign mem_chipselect = fwd;
  assign mem_write      = fwd & cmd_sel.write;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Gating with reset kills a read that was still in the pipe when reset arrived.
  always_comb begin
    rd_valid         = tag_q.valid & ~reset;
    rd_data          = tag_q.oob ? '0 : mem_readdata;
    m0_readdatavalid = rd_valid & ~tag_q.owner;
    m1_readdatavalid = rd_valid & tag_q.owner;
    m0_readdata      = m0_readdatavalid ? rd_data : '0;
    m1_readdata      = m1_readdatavalid ? rd_data : '0;
  end

endmodule
